// File: rtl/hp_read_arbiter.sv
// Two-requester round-robin arbiter onto one Zynq HP AXI read port.
// Remaps AR into the fabric DDR window, tags ARID with the requester index and routes R back by tag.
module hp_read_arbiter #(
    parameter int          ID_W     = 5,
    parameter int          DATA_W   = 64,
    parameter int          MAX_OUT  = 4,
    parameter logic [3:0]  WIN_BASE = 4'h1
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              s0_ar_valid,
    output logic              s0_ar_ready,
    input  logic [31:0]       s0_ar_addr,
    input  logic [ID_W-1:0]   s0_ar_id,
    input  logic [7:0]        s0_ar_len,
    input  logic [2:0]        s0_ar_size,
    input  logic [1:0]        s0_ar_burst,
    output logic              s0_r_valid,
    input  logic              s0_r_ready,
    output logic [ID_W-1:0]   s0_r_id,
    output logic [DATA_W-1:0] s0_r_data,
    output logic [1:0]        s0_r_resp,
    output logic              s0_r_last,

    input  logic              s1_ar_valid,
    output logic              s1_ar_ready,
    input  logic [31:0]       s1_ar_addr,
    input  logic [ID_W-1:0]   s1_ar_id,
    input  logic [7:0]        s1_ar_len,
    input  logic [2:0]        s1_ar_size,
    input  logic [1:0]        s1_ar_burst,
    output logic              s1_r_valid,
    input  logic              s1_r_ready,
    output logic [ID_W-1:0]   s1_r_id,
    output logic [DATA_W-1:0] s1_r_data,
    output logic [1:0]        s1_r_resp,
    output logic              s1_r_last,

    output logic              m_ar_valid,
    input  logic              m_ar_ready,
    output logic [31:0]       m_ar_addr,
    output logic [ID_W:0]     m_ar_id,
    output logic [7:0]        m_ar_len,
    output logic [2:0]        m_ar_size,
    output logic [1:0]        m_ar_burst,
    output logic [3:0]        m_ar_cache,
    output logic [2:0]        m_ar_prot,
    output logic [3:0]        m_ar_qos,
    output logic              m_ar_lock,

    input  logic              m_r_valid,
    output logic              m_r_ready,
    input  logic [ID_W:0]     m_r_id,
    input  logic [DATA_W-1:0] m_r_data,
    input  logic [1:0]        m_r_resp,
    input  logic              m_r_last,

    output logic              err_unexpected
);

    localparam logic [3:0] MAX_C = 4'(MAX_OUT);

    logic              ar_vld_q, ar_vld_d;
    logic [27:0]       ar_addr_q, ar_addr_d;
    logic [ID_W:0]     ar_id_q, ar_id_d;
    logic [7:0]        ar_len_q, ar_len_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [1:0]        ar_burst_q, ar_burst_d;
    logic              last_q, last_d;
    logic [3:0]        cnt_q [2];
    logic [3:0]        cnt_d [2];
    logic              err_q, err_d;

    logic              can_load, grant, win, tag, r_done;
    logic [1:0]        elig, inc, dec;
    logic              unused_addr_hi;

    // The window base replaces the top nibble, so those address bits are never stored.
    assign unused_addr_hi = ^{s0_ar_addr[31:28], s1_ar_addr[31:28]};

    assign can_load = !ar_vld_q || m_ar_ready;
    assign elig[0]  = s0_ar_valid && (cnt_q[0] < MAX_C);
    assign elig[1]  = s1_ar_valid && (cnt_q[1] < MAX_C);
    assign win      = (elig[0] && elig[1]) ? !last_q : elig[1];
    assign grant    = reset_n && can_load && (elig != 2'b00);

    assign s0_ar_ready = grant && !win;
    assign s1_ar_ready = grant && win;

    assign m_ar_valid = ar_vld_q;
    assign m_ar_addr  = {WIN_BASE, ar_addr_q};
    assign m_ar_id    = ar_id_q;
    assign m_ar_len   = ar_len_q;
    assign m_ar_size  = ar_size_q;
    assign m_ar_burst = ar_burst_q;
    assign m_ar_cache = 4'b0011;
    assign m_ar_prot  = 3'b000;
    assign m_ar_qos   = 4'b0000;
    assign m_ar_lock  = 1'b0;

    assign tag        = m_r_id[ID_W];
    assign s0_r_valid = m_r_valid && !tag;
    assign s1_r_valid = m_r_valid && tag;
    assign m_r_ready  = tag ? s1_r_ready : s0_r_ready;
    assign s0_r_id    = m_r_id[ID_W-1:0];
    assign s1_r_id    = m_r_id[ID_W-1:0];
    assign s0_r_data  = m_r_data;
    assign s1_r_data  = m_r_data;
    assign s0_r_resp  = m_r_resp;
    assign s1_r_resp  = m_r_resp;
    assign s0_r_last  = m_r_last;
    assign s1_r_last  = m_r_last;

    assign r_done = m_r_valid && m_r_ready && m_r_last;
    assign inc    = {s1_ar_valid && s1_ar_ready, s0_ar_valid && s0_ar_ready};
    assign dec    = {r_done && tag, r_done && !tag};

    always_comb begin
        ar_vld_d   = ar_vld_q;
        ar_addr_d  = ar_addr_q;
        ar_id_d    = ar_id_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        last_d     = last_q;
        cnt_d[0]   = cnt_q[0];
        cnt_d[1]   = cnt_q[1];
        err_d      = err_q;

        if (can_load) begin
            ar_vld_d = grant;
        end
        if (grant) begin
            last_d     = win;
            ar_addr_d  = win ? s1_ar_addr[27:0] : s0_ar_addr[27:0];
            ar_id_d    = {win, (win ? s1_ar_id : s0_ar_id)};
            ar_len_d   = win ? s1_ar_len   : s0_ar_len;
            ar_size_d  = win ? s1_ar_size  : s0_ar_size;
            ar_burst_d = win ? s1_ar_burst : s0_ar_burst;
        end

        // An rlast for a requester with nothing outstanding is flagged rather than underflowing.
        for (int k = 0; k < 2; k++) begin
            if (inc[k] && !dec[k]) begin
                cnt_d[k] = cnt_q[k] + 4'd1;
            end else if (dec[k] && !inc[k]) begin
                if (cnt_q[k] == 4'd0) err_d = 1'b1;
                else                  cnt_d[k] = cnt_q[k] - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ar_vld_q   <= 1'b0;
            ar_addr_q  <= '0;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            last_q     <= 1'b1;
            cnt_q[0]   <= 4'd0;
            cnt_q[1]   <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            ar_vld_q   <= ar_vld_d;
            ar_addr_q  <= ar_addr_d;
            ar_id_q    <= ar_id_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            last_q     <= last_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            err_q      <= err_d;
        end
    end

    assign err_unexpected = err_q;

endmodule

// File: tb/tb_hp_read_arbiter.sv
// Self-checking bench for hp_read_arbiter: per-scenario tasks plus a scoreboard of AR and R transfers.
module tb_hp_read_arbiter;

    localparam int ID_W   = 5;
    localparam int DATA_W = 64;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              s0_ar_valid, s0_ar_ready, s1_ar_valid, s1_ar_ready;
    logic [31:0]       s0_ar_addr, s1_ar_addr;
    logic [ID_W-1:0]   s0_ar_id, s1_ar_id;
    logic [7:0]        s0_ar_len, s1_ar_len;
    logic [2:0]        s0_ar_size, s1_ar_size;
    logic [1:0]        s0_ar_burst, s1_ar_burst;
    logic              s0_r_valid, s0_r_ready, s1_r_valid, s1_r_ready;
    logic [ID_W-1:0]   s0_r_id, s1_r_id;
    logic [DATA_W-1:0] s0_r_data, s1_r_data;
    logic [1:0]        s0_r_resp, s1_r_resp;
    logic              s0_r_last, s1_r_last;
    logic              m_ar_valid, m_ar_ready;
    logic [31:0]       m_ar_addr;
    logic [ID_W:0]     m_ar_id;
    logic [7:0]        m_ar_len;
    logic [2:0]        m_ar_size;
    logic [1:0]        m_ar_burst;
    logic [3:0]        m_ar_cache, m_ar_qos;
    logic [2:0]        m_ar_prot;
    logic              m_ar_lock;
    logic              m_r_valid, m_r_ready;
    logic [ID_W:0]     m_r_id;
    logic [DATA_W-1:0] m_r_data;
    logic [1:0]        m_r_resp;
    logic              m_r_last;
    logic              err_unexpected;

    always #5 clock = ~clock;

    hp_read_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr),
        .s0_ar_id(s0_ar_id), .s0_ar_len(s0_ar_len), .s0_ar_size(s0_ar_size), .s0_ar_burst(s0_ar_burst),
        .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_id(s0_r_id), .s0_r_data(s0_r_data),
        .s0_r_resp(s0_r_resp), .s0_r_last(s0_r_last),
        .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr),
        .s1_ar_id(s1_ar_id), .s1_ar_len(s1_ar_len), .s1_ar_size(s1_ar_size), .s1_ar_burst(s1_ar_burst),
        .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_id(s1_r_id), .s1_r_data(s1_r_data),
        .s1_r_resp(s1_r_resp), .s1_r_last(s1_r_last),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
        .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
        .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos), .m_ar_lock(m_ar_lock),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
        .m_r_resp(m_r_resp), .m_r_last(m_r_last),
        .err_unexpected(err_unexpected)
    );

    typedef struct packed {
        logic [ID_W:0] id;
        logic [31:0]   addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } ar_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_t;

    ar_t ar_q[$];
    r_t  r0_q[$];
    r_t  r1_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  exp_last;
    int  exp_cnt[2];

    // Reference grant decision from the bench's own view of counts and last winner.
    function automatic logic [1:0] exp_grant(input logic can_load);
        logic e0, e1;
        e0 = s0_ar_valid && (exp_cnt[0] < 4);
        e1 = s1_ar_valid && (exp_cnt[1] < 4);
        if (!can_load) return 2'b00;
        if (e0 && e1)  return exp_last ? 2'b01 : 2'b10;
        return {e1, e0};
    endfunction

    task automatic commit_grant(input logic [1:0] g);
        ar_t e;
        if (g[0]) begin
            e = '{id: {1'b0, s0_ar_id}, addr: {4'h1, s0_ar_addr[27:0]}, len: s0_ar_len,
                  size: s0_ar_size, burst: s0_ar_burst};
            ar_q.push_back(e);
            exp_cnt[0]++;
            exp_last = 1'b0;
        end
        if (g[1]) begin
            e = '{id: {1'b1, s1_ar_id}, addr: {4'h1, s1_ar_addr[27:0]}, len: s1_ar_len,
                  size: s1_ar_size, burst: s1_ar_burst};
            ar_q.push_back(e);
            exp_cnt[1]++;
            exp_last = 1'b1;
        end
    endtask

    task automatic push_r(input int k, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                          input logic [1:0] resp, input logic last);
        r_t e;
        e = '{id: id, data: d, resp: resp, last: last};
        if (k == 0) r0_q.push_back(e);
        else        r1_q.push_back(e);
        if (last && exp_cnt[k] > 0) exp_cnt[k]--;
    endtask

    task automatic do_reset();
        @(negedge clock);
        s0_ar_valid = 0; s1_ar_valid = 0; m_r_valid = 0; m_r_last = 0;
        m_ar_ready = 1; s0_r_ready = 1; s1_r_ready = 1;
        @(negedge clock);
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        exp_last = 1'b1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
    endtask

    // Scoreboard side: every transfer the DUT completes is matched against the queue head.
    always @(posedge clock) begin
        ar_t ea;
        r_t  er;
        if (m_ar_valid && m_ar_ready) begin
            n_vec++;
            if (ar_q.size() == 0) begin
                n_err++;
                $display("FAIL ar_sb_unexpected: got id=%h addr=%h, queue empty", m_ar_id, m_ar_addr);
            end else begin
                ea = ar_q.pop_front();
                if ({m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst,
                     m_ar_cache, m_ar_prot, m_ar_qos, m_ar_lock} !== {ea, 12'b0011_000_0000_0}) begin
                    n_err++;
                    $display("FAIL ar_sb: got id=%h addr=%h len=%h cache=%b, exp id=%h addr=%h len=%h cache=0011",
                             m_ar_id, m_ar_addr, m_ar_len, m_ar_cache, ea.id, ea.addr, ea.len);
                end
            end
        end
        if (s0_r_valid && s0_r_ready) begin
            n_vec++;
            if (r0_q.size() == 0) begin
                n_err++;
                $display("FAIL r0_sb_unexpected: got data=%h, queue empty", s0_r_data);
            end else begin
                er = r0_q.pop_front();
                if ({s0_r_id, s0_r_data, s0_r_resp, s0_r_last} !== er) begin
                    n_err++;
                    $display("FAIL r0_sb: got id=%h data=%h last=%b, exp id=%h data=%h last=%b",
                             s0_r_id, s0_r_data, s0_r_last, er.id, er.data, er.last);
                end
            end
        end
        if (s1_r_valid && s1_r_ready) begin
            n_vec++;
            if (r1_q.size() == 0) begin
                n_err++;
                $display("FAIL r1_sb_unexpected: got data=%h, queue empty", s1_r_data);
            end else begin
                er = r1_q.pop_front();
                if ({s1_r_id, s1_r_data, s1_r_resp, s1_r_last} !== er) begin
                    n_err++;
                    $display("FAIL r1_sb: got id=%h data=%h last=%b, exp id=%h data=%h last=%b",
                             s1_r_id, s1_r_data, s1_r_last, er.id, er.data, er.last);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clock);
        reset_n = 0; s0_ar_valid = 1; s1_ar_valid = 1;
        #1;
        n_vec++;
        if ({s1_ar_ready, s0_ar_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready: got %b exp 00", {s1_ar_ready, s0_ar_ready});
        end
        @(negedge clock);
        s0_ar_valid = 0; s1_ar_valid = 0; reset_n = 1;
        exp_last = 1'b1; exp_cnt[0] = 0; exp_cnt[1] = 0;
        #1;
        n_vec++;
        if ({m_ar_valid, err_unexpected, dut.cnt_q[0], dut.cnt_q[1]} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b err=%b cnt0=%0d cnt1=%0d exp all 0",
                     m_ar_valid, err_unexpected, dut.cnt_q[0], dut.cnt_q[1]);
        end
    endtask

    task automatic test_single_read();
        logic [1:0] g;
        @(negedge clock);
        s0_ar_valid = 1; s0_ar_addr = 32'h0000_1000; s0_ar_id = 5'd3; s0_ar_len = 8'd7;
        s0_ar_size = 3'd3; s0_ar_burst = 2'd1;
        #1;
        g = exp_grant(1'b1);
        n_vec++;
        if ({s1_ar_ready, s0_ar_ready} !== 2'b01) begin
            n_err++; $display("FAIL single_ready: got %b exp 01", {s1_ar_ready, s0_ar_ready});
        end
        commit_grant(g);
        @(negedge clock);
        s0_ar_valid = 0;
        #1;
        n_vec++;
        if ({m_ar_valid, m_ar_addr, m_ar_id, dut.cnt_q[0]} !== {1'b1, 32'h1000_1000, 6'h03, 4'd1}) begin
            n_err++;
            $display("FAIL single_ar: got v=%b addr=%h id=%h cnt=%0d exp v=1 addr=10001000 id=03 cnt=1",
                     m_ar_valid, m_ar_addr, m_ar_id, dut.cnt_q[0]);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            m_r_valid = 1; m_r_id = 6'h03; m_r_data = 64'hA000 + 64'(i); m_r_resp = 2'b00;
            m_r_last = (i == 7);
            #1;
            n_vec++;
            if ({s0_r_valid, s1_r_valid, m_r_ready, s0_r_id} !== {3'b101, 5'd3}) begin
                n_err++;
                $display("FAIL single_r_route beat %0d: got s0v=%b s1v=%b rdy=%b id=%h exp 1 0 1 03",
                         i, s0_r_valid, s1_r_valid, m_r_ready, s0_r_id);
            end
            push_r(0, 5'd3, 64'hA000 + 64'(i), 2'b00, i == 7);
        end
        @(negedge clock);
        m_r_valid = 0; m_r_last = 0;
        #1;
        n_vec++;
        if (dut.cnt_q[0] !== 4'd0) begin
            n_err++; $display("FAIL single_cnt_after_last: got %0d exp 0", dut.cnt_q[0]);
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            s0_ar_valid = 1; s0_ar_addr = 32'hF000_0100 + 32'(i); s0_ar_id = 5'd1; s0_ar_len = 8'(i);
            s1_ar_valid = 1; s1_ar_addr = 32'h2000_0200 + 32'(i); s1_ar_id = 5'd2; s1_ar_len = 8'(i);
            #1;
            n_vec++;
            if ({s1_ar_ready, s0_ar_ready} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL contention_grant %0d: got %b exp %b", i, {s1_ar_ready, s0_ar_ready},
                         (i % 2 == 1) ? 2'b10 : 2'b01);
            end
            if (i > 0) begin
                n_vec++;
                if (m_ar_id[ID_W] !== 1'((i - 1) % 2)) begin
                    n_err++;
                    $display("FAIL contention_tag %0d: got %b exp %0d", i, m_ar_id[ID_W], (i - 1) % 2);
                end
            end
            commit_grant((i % 2 == 1) ? 2'b10 : 2'b01);
        end
        @(negedge clock);
        s0_ar_valid = 0; s1_ar_valid = 0;
    endtask

    task automatic test_limit();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            s1_ar_valid = 1; s1_ar_addr = 32'h0000_0300 + 32'(i * 256); s1_ar_id = 5'd7;
            #1;
            n_vec++;
            if ({s1_ar_ready, s0_ar_ready} !== 2'b10) begin
                n_err++; $display("FAIL limit_fill %0d: got %b exp 10", i, {s1_ar_ready, s0_ar_ready});
            end
            commit_grant(2'b10);
        end
        @(negedge clock);
        s0_ar_valid = 1; s0_ar_addr = 32'h0000_4000; s0_ar_id = 5'd0;
        #1;
        n_vec++;
        if ({s1_ar_ready, s0_ar_ready} !== 2'b01) begin
            n_err++; $display("FAIL limit_full: got %b exp 01", {s1_ar_ready, s0_ar_ready});
        end
        commit_grant(2'b01);
        @(negedge clock);
        s0_ar_valid = 0;
        m_r_valid = 1; m_r_id = {1'b1, 5'd7}; m_r_data = 64'hBEEF; m_r_resp = 2'b00; m_r_last = 1;
        #1;
        n_vec++;
        if ({s1_ar_ready, m_r_ready} !== 2'b01) begin
            n_err++; $display("FAIL limit_same_cycle: got ready=%b rrdy=%b exp 0 1", s1_ar_ready, m_r_ready);
        end
        push_r(1, 5'd7, 64'hBEEF, 2'b00, 1'b1);
        @(negedge clock);
        m_r_valid = 0; m_r_last = 0;
        #1;
        n_vec++;
        if (s1_ar_ready !== exp_grant(1'b1)[1] || s1_ar_ready !== 1'b1) begin
            n_err++; $display("FAIL limit_regrant: got %b exp 1", s1_ar_ready);
        end
        commit_grant(2'b10);
        @(negedge clock);
        s1_ar_valid = 0;
    endtask

    task automatic test_backpressure();
        @(negedge clock);
        m_ar_ready = 0;
        s0_ar_valid = 1; s0_ar_addr = 32'h0000_A000; s0_ar_id = 5'd4; s0_ar_len = 8'd3;
        #1;
        n_vec++;
        if ({s1_ar_ready, s0_ar_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_first: got %b exp 01", {s1_ar_ready, s0_ar_ready});
        end
        commit_grant(2'b01);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (c == 0) begin
                s0_ar_addr = 32'h0000_B000; s0_ar_id = 5'd5; s0_ar_len = 8'd1;
                s1_ar_valid = 1; s1_ar_addr = 32'h0000_C000; s1_ar_id = 5'd6; s1_ar_len = 8'd2;
            end
            #1;
            n_vec++;
            if ({m_ar_valid, m_ar_addr, m_ar_id, m_ar_len, s1_ar_ready, s0_ar_ready} !==
                {1'b1, 32'h1000_A000, 6'h04, 8'd3, 2'b00}) begin
                n_err++;
                $display("FAIL bp_hold %0d: got v=%b addr=%h id=%h len=%h rdy=%b exp 1 1000a000 04 03 00",
                         c, m_ar_valid, m_ar_addr, m_ar_id, m_ar_len, {s1_ar_ready, s0_ar_ready});
            end
        end
        @(negedge clock);
        m_ar_ready = 1;
        #1;
        n_vec++;
        if ({s1_ar_ready, s0_ar_ready} !== 2'b10) begin
            n_err++; $display("FAIL bp_release: got %b exp 10", {s1_ar_ready, s0_ar_ready});
        end
        commit_grant(2'b10);
        @(negedge clock);
        s1_ar_valid = 0;
        #1;
        n_vec++;
        if ({m_ar_addr, m_ar_id, s1_ar_ready, s0_ar_ready} !== {32'h1000_C000, 6'h26, 2'b01}) begin
            n_err++;
            $display("FAIL bp_after: got addr=%h id=%h rdy=%b exp 1000c000 26 01",
                     m_ar_addr, m_ar_id, {s1_ar_ready, s0_ar_ready});
        end
        commit_grant(2'b01);
        @(negedge clock);
        s0_ar_valid = 0;
    endtask

    task automatic test_interleaved_r();
        logic [5:0]  tags;
        logic [5:0]  lasts;
        logic [DATA_W-1:0] d;
        tags  = 6'b000011;
        lasts = 6'b100010;
        @(negedge clock);
        s0_ar_valid = 1; s0_ar_addr = 32'h0000_0040; s0_ar_id = 5'd2; s0_ar_len = 8'd3;
        s1_ar_valid = 1; s1_ar_addr = 32'h0000_0080; s1_ar_id = 5'd9; s1_ar_len = 8'd1;
        #1;
        n_vec++;
        if ({s1_ar_ready, s0_ar_ready} !== exp_grant(1'b1)) begin
            n_err++; $display("FAIL ilv_ar0: got %b exp %b", {s1_ar_ready, s0_ar_ready}, exp_grant(1'b1));
        end
        commit_grant(exp_grant(1'b1));
        @(negedge clock);
        s0_ar_valid = 0;
        #1;
        n_vec++;
        if ({s1_ar_ready, s0_ar_ready} !== 2'b10) begin
            n_err++; $display("FAIL ilv_ar1: got %b exp 10", {s1_ar_ready, s0_ar_ready});
        end
        commit_grant(2'b10);
        @(negedge clock);
        s1_ar_valid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            m_r_valid = 1; m_r_id = {1'b1, 5'd9}; m_r_data = 64'h1111_0000; m_r_last = 0;
            m_r_resp = 2'b00; s1_r_ready = 0;
            #1;
            n_vec++;
            if ({m_r_ready, s0_r_valid, s1_r_valid} !== 3'b001) begin
                n_err++;
                $display("FAIL ilv_stall %0d: got rrdy=%b s0v=%b s1v=%b exp 0 0 1",
                         c, m_r_ready, s0_r_valid, s1_r_valid);
            end
        end
        for (int b = 0; b < 6; b++) begin
            @(negedge clock);
            s1_r_ready = 1;
            d = (tags[b] ? 64'h1111_0000 : 64'h2222_0000) + 64'(b);
            m_r_valid = 1; m_r_id = {tags[b], (tags[b] ? 5'd9 : 5'd2)}; m_r_data = d;
            m_r_last = lasts[b]; m_r_resp = 2'(b);
            #1;
            n_vec++;
            if ({m_r_ready, s1_r_valid, s0_r_valid} !== {1'b1, tags[b], !tags[b]}) begin
                n_err++;
                $display("FAIL ilv_route %0d: got rrdy=%b s1v=%b s0v=%b exp 1 %b %b",
                         b, m_r_ready, s1_r_valid, s0_r_valid, tags[b], !tags[b]);
            end
            push_r(tags[b] ? 1 : 0, tags[b] ? 5'd9 : 5'd2, d, 2'(b), lasts[b]);
        end
        @(negedge clock);
        m_r_valid = 0; m_r_last = 0;
        #1;
        n_vec++;
        if ({dut.cnt_q[0], dut.cnt_q[1]} !== 8'h00) begin
            n_err++; $display("FAIL ilv_cnt: got %0d %0d exp 0 0", dut.cnt_q[0], dut.cnt_q[1]);
        end
    endtask

    task automatic test_error_reset();
        @(negedge clock);
        m_r_valid = 1; m_r_id = 6'h00; m_r_data = 64'hDEAD; m_r_resp = 2'b10; m_r_last = 1;
        #1;
        push_r(0, 5'd0, 64'hDEAD, 2'b10, 1'b1);
        @(negedge clock);
        m_r_valid = 0; m_r_last = 0;
        #1;
        n_vec++;
        if (err_unexpected !== 1'b1) begin
            n_err++; $display("FAIL err_set: got %b exp 1", err_unexpected);
        end
        @(negedge clock);
        m_ar_ready = 0; s0_ar_valid = 1; s0_ar_addr = 32'h0000_5000; s0_ar_id = 5'd1;
        @(negedge clock);
        s0_ar_valid = 0;
        #1;
        n_vec++;
        if ({err_unexpected, m_ar_valid} !== 2'b11) begin
            n_err++; $display("FAIL err_sticky: got err=%b v=%b exp 1 1", err_unexpected, m_ar_valid);
        end
        @(negedge clock);
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        #1;
        n_vec++;
        if ({m_ar_valid, err_unexpected} !== 2'b00) begin
            n_err++; $display("FAIL err_reset: got v=%b err=%b exp 0 0", m_ar_valid, err_unexpected);
        end
        m_ar_ready = 1;
        exp_last = 1'b1; exp_cnt[0] = 0; exp_cnt[1] = 0;
    endtask

    initial begin
        reset_n = 0;
        s0_ar_valid = 0; s0_ar_addr = '0; s0_ar_id = '0; s0_ar_len = '0; s0_ar_size = 3'd3; s0_ar_burst = 2'd1;
        s1_ar_valid = 0; s1_ar_addr = '0; s1_ar_id = '0; s1_ar_len = '0; s1_ar_size = 3'd3; s1_ar_burst = 2'd1;
        s0_r_ready = 1; s1_r_ready = 1;
        m_ar_ready = 1; m_r_valid = 0; m_r_id = '0; m_r_data = '0; m_r_resp = '0; m_r_last = 0;
        exp_last = 1'b1; exp_cnt[0] = 0; exp_cnt[1] = 0;

        test_reset();
        test_single_read();
        do_reset();
        test_contention();
        do_reset();
        test_limit();
        do_reset();
        test_backpressure();
        do_reset();
        test_interleaved_r();
        do_reset();
        test_error_reset();

        repeat (3) @(negedge clock);
        n_vec++;
        if (ar_q.size() != 0 || r0_q.size() != 0 || r1_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: left ar=%0d r0=%0d r1=%0d exp 0 0 0",
                     ar_q.size(), r0_q.size(), r1_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
